aes_key_schedule_ctrl: RTL and testbench
========================================

// Module: aes_key_schedule_ctrl
// PURPOSE
//  Sequences the existing getNextKey datapath through AES-128 rounds 1..10: generates rcon, holds each
//  round's inputs stable for the S-box latency, then captures the result. Stores all 11 round keys
//  (rk[0] = cipher key). Sits between the key-load path and the cipher core.
//  The cipher core reads round keys by index through a registered read port.
// PARAMETERS
//  NUM_ROUNDS   10  rounds to expand; rk array holds NUM_ROUNDS+1 entries
//  GNK_LATENCY  1   clock edges after which getNextKey.nextKey is valid, with currKey/rcon held stable
// PORTS
//  clk        in   1    system clock; all state updates on posedge
//  reset_n    in   1    asynchronous, active-low reset
//  start      in   1    request expansion of key; accepted only when start && ready at a posedge
//  key        in   128  cipher key, sampled on the accept edge
//  ready      out  1    high in IDLE and DONE (can accept start)
//  busy       out  1    high in EXPAND
//  done       out  1    one-cycle pulse, the cycle after the round-NUM_ROUNDS key is captured
//  keys_valid out  1    level; high from done until the next accepted start or reset
//  rd_idx     in   4    round-key index 0..NUM_ROUNDS
//  rd_key     out  128  rk[rd_idx], registered (valid the cycle after rd_idx is applied)
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE; ready=1, busy=0, done=0, keys_valid=0, rd_key=0, round=0,
//   wait counter=0, rcon=32'h01000000; rk[] contents are not reset.
//  FSM: IDLE --start--> EXPAND --round==NUM_ROUNDS captured--> DONE --start--> EXPAND.
//   DONE behaves as IDLE but keeps keys_valid=1.
//  Accept edge E0: rk[0]<=key; currKey reg<=key; rcon<=32'h01000000; round<=1; wait cnt<=0;
//   keys_valid<=0; state<=EXPAND.
//  Per round r: currKey/rcon are held constant for GNK_LATENCY+1 cycles. At the last edge of the
//   round: rk[r]<=nextKey; currKey<=nextKey; rcon<={xtime(rcon[31:24]),24'h0}; round<=r+1.
//   xtime = {b[6:0],1'b0} ^ (b[7] ? 8'h1B : 8'h00), giving 01,02,04,08,10,20,40,80,1B,36.
//  Latency (GNK_LATENCY=1): rk[r] is written at edge E(2r); rk[10] at E20.
//   At E20 the FSM enters DONE, and done=1, keys_valid=1 during cycle 20..21.
//  start while busy: ignored. No queuing; key input is not sampled.
//  start during the done-pulse cycle: accepted (ready=1). done still pulses exactly once.
//   keys_valid returns to 0 at that edge.
//  Reset mid-expansion: immediate return to IDLE with keys_valid=0. Partially written rk[] is
//   stale; a later start rewrites every entry.
//  Read port: rd_key<=(rd_idx<=NUM_ROUNDS) ? rk[rd_idx] : 128'h0 every cycle, independent of state.
//   Entries not yet written in the current expansion return stale data; consumers gate on keys_valid.
//  Widths: round counter is 4 bits; wait counter is $clog2(GNK_LATENCY+1) bits, min 1.
//   rcon is 32 bits with the low 24 bits always 0.
// STRUCTURE
//  aes_pkg (shared): NUM_ROUNDS, RCON_INIT=32'h01000000, typedef logic [127:0] round_key_t,
//   function xtime(logic [7:0]) -> logic [7:0], typedef enum {IDLE,EXPAND,DONE} ks_state_t.
//  One sub-module: existing getNextKey (clk, currKey, rcon, nextKey), instanced once.
//  Everything else (FSM, counters, rk register file, read mux) lives in this module.
// TESTING
//  1 FIPS-197 A.1: start with key=2B7E151628AED2A6ABF7158809CF4F3C -> rk[1]=A0FAFE1788542CB123A339392A6C7605,
//    rk[10]=D014F9A8C9EE2589E13F0CC8B6630CA6; done exactly 20 cycles after the accept edge.
//    Read all 11 keys via rd_idx; each rd_key matches one cycle later.
//  2 All-zero key -> rk[10]=B4EF5BCB3E92E21123E951CF6F8F188E. Check internal rcon at round 9 = 32'h1B000000.
//  3 Pulse start with a different key at cycles 3 and 10 of an expansion -> ignored;
//    results equal scenario 1; a single done pulse.
//  4 Assert reset_n=0 during round 5 -> busy=0, keys_valid=0 asynchronously. Then restart with the
//    A.1 key -> full match.
//  5 Back-to-back: start asserted in the done cycle with the zero key -> accepted; keys_valid drops;
//    zero-key results 20 cycles later.
//  6 rd_idx=11..15 -> rd_key=0; rd_idx=0 after completion -> the cipher key.

Source files
------------

// File: rtl/aes_key_schedule_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : aes_key_schedule_ctrl_pkg                                     |
// | Brief    : Shared AES-128 key-schedule types, constants and GF helpers   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package aes_key_schedule_ctrl_pkg;

  localparam int          NUM_ROUNDS = 10;
  localparam logic [31:0] RCON_INIT  = 32'h01000000;

  typedef logic [127:0] round_key_t;

  typedef enum logic [1:0] {
    KS_IDLE   = 2'd0,
    KS_EXPAND = 2'd1,
    KS_DONE   = 2'd2
  } ks_state_t;

  // Multiply by x in GF(2^8) with the AES reduction polynomial
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = xtime(sh);
    end
    return acc;
  endfunction

  // a^254 is the multiplicative inverse (and maps 0 to 0)
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] res;
    logic [7:0] pw;
    res = 8'h01;
    pw  = a;
    for (int i = 0; i < 7; i++) begin
      pw  = gf_mul(pw, pw);
      res = gf_mul(res, pw);
    end
    return res;
  endfunction

  // Forward S-box: inversion followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_schedule_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : aes_key_schedule_ctrl_if                                      |
// | Brief    : Start/status handshake and round-key read port bundle         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface aes_key_schedule_ctrl_if;
  import aes_key_schedule_ctrl_pkg::*;

  logic       start;
  round_key_t key;
  logic       ready;
  logic       busy;
  logic       done;
  logic       keys_valid;
  logic [3:0] rd_idx;
  round_key_t rd_key;

  modport master (
    output start, key, rd_idx,
    input  ready, busy, done, keys_valid, rd_key
  );

  modport slave (
    input  start, key, rd_idx,
    output ready, busy, done, keys_valid, rd_key
  );
endinterface
`default_nettype wire

// File: rtl/aes_key_schedule_ctrl_gnk.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : getNextKey                                                    |
// | Brief    : One AES-128 key-expansion step, result registered (1 edge)    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module getNextKey
  import aes_key_schedule_ctrl_pkg::*;
(
  input  wire logic        clk,
  input  wire round_key_t  currKey,
  input  wire logic [31:0] rcon,
  output round_key_t       nextKey
);

  logic [31:0] w_rot;
  logic [31:0] w_temp;
  logic [31:0] w_n0;
  logic [31:0] w_n1;
  logic [31:0] w_n2;
  logic [31:0] w_n3;

  // RotWord/SubWord/rcon on the last word, then the running XOR chain
  always_comb begin
    w_rot  = {currKey[23:0], currKey[31:24]};
    w_temp = {sbox(w_rot[31:24]), sbox(w_rot[23:16]),
              sbox(w_rot[15:8]),  sbox(w_rot[7:0])} ^ rcon;
    w_n0   = currKey[127:96] ^ w_temp;
    w_n1   = currKey[95:64]  ^ w_n0;
    w_n2   = currKey[63:32]  ^ w_n1;
    w_n3   = currKey[31:0]   ^ w_n2;
  end

  // Register the expanded key; valid one edge after inputs settle
  always_ff @(posedge clk) begin
    nextKey <= {w_n0, w_n1, w_n2, w_n3};
  end

endmodule
`default_nettype wire

// File: rtl/aes_key_schedule_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : aes_key_schedule_ctrl                                         |
// | Brief    : Sequences getNextKey through all rounds, stores round keys    |
// |            and serves them through a registered read port               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module aes_key_schedule_ctrl
  import aes_key_schedule_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS  = aes_key_schedule_ctrl_pkg::NUM_ROUNDS,
  parameter int GNK_LATENCY = 1
) (
  input wire logic                clk,
  input wire logic                reset_n,
  aes_key_schedule_ctrl_if.slave  bus
);

  localparam int              WAIT_W    = (GNK_LATENCY > 0) ? $clog2(GNK_LATENCY + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(GNK_LATENCY);
  localparam logic [3:0]      LAST_IDX  = 4'(NUM_ROUNDS);

  localparam logic [1:0] S_IDLE   = KS_IDLE;
  localparam logic [1:0] S_EXPAND = KS_EXPAND;
  localparam logic [1:0] S_DONE   = KS_DONE;

  logic [1:0]        r_state;
  logic [3:0]        r_round;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [31:0]       r_rcon;
  round_key_t        r_curr_key;
  logic              r_done;
  logic              r_keys_valid;
  round_key_t        r_rd_key;
  round_key_t        r_rk [0:NUM_ROUNDS];
  round_key_t        w_next_key;
  logic              w_accept;
  logic              w_capture;

  // DONE is a parked IDLE, so both accept a new key
  assign bus.ready      = (r_state == S_IDLE) || (r_state == S_DONE);
  assign bus.busy       = (r_state == S_EXPAND);
  assign bus.done       = r_done;
  assign bus.keys_valid = r_keys_valid;
  assign bus.rd_key     = r_rd_key;

  assign w_accept  = bus.start && bus.ready;
  assign w_capture = (r_state == S_EXPAND) && (r_wait_cnt == WAIT_LAST);

  getNextKey u_gnk (
    .clk     (clk),
    .currKey (r_curr_key),
    .rcon    (r_rcon),
    .nextKey (w_next_key)
  );

  // Sequencer: hold currKey/rcon for the datapath latency, then capture and advance
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_round      <= 4'd0;
      r_wait_cnt   <= '0;
      r_rcon       <= RCON_INIT;
      r_curr_key   <= '0;
      r_done       <= 1'b0;
      r_keys_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_curr_key   <= bus.key;
            r_rcon       <= RCON_INIT;
            r_round      <= 4'd1;
            r_wait_cnt   <= '0;
            r_keys_valid <= 1'b0;
            r_state      <= S_EXPAND;
          end
        end
        S_EXPAND: begin
          if (r_wait_cnt == WAIT_LAST) begin
            r_curr_key <= w_next_key;
            r_rcon     <= {xtime(r_rcon[31:24]), 24'h0};
            r_round    <= r_round + 4'd1;
            r_wait_cnt <= '0;
            if (r_round == LAST_IDX) begin
              r_state      <= S_DONE;
              r_done       <= 1'b1;
              r_keys_valid <= 1'b1;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Round-key storage; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (w_accept) r_rk[0] <= bus.key;
    if (w_capture) r_rk[r_round] <= w_next_key;
  end

  // Registered read port, zero for out-of-range indices
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_key <= '0;
    end else begin
      r_rd_key <= (bus.rd_idx <= LAST_IDX) ? r_rk[bus.rd_idx] : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_key_schedule_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_aes_key_schedule_ctrl                                      |
// | Brief    : Directed self-checking bench for aes_key_schedule_ctrl        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_aes_key_schedule_ctrl;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  int   n;
  int   extra_done;

  logic [127:0] a1_rk [0:10];
  logic [127:0] a1_key;
  logic [127:0] zero_rk1;
  logic [127:0] zero_rk10;

  aes_key_schedule_ctrl_if ks_if ();

  aes_key_schedule_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ks_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges, landing 1 time unit after the last edge
  task automatic step(input int cnt);
    repeat (cnt) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Count edges until done is seen, bounded
  task automatic wait_done(output int cnt);
    cnt = 0;
    while (ks_if.done !== 1'b1 && cnt < 60) begin
      step(1);
      cnt++;
    end
  endtask

  task automatic accept_key(input logic [127:0] k);
    ks_if.start = 1'b1;
    ks_if.key   = k;
    step(1);
    ks_if.start = 1'b0;
  endtask

  task automatic read_key(input int idx, input string tag, input logic [127:0] exp);
    ks_if.rd_idx = 4'(idx);
    step(1);
    check(tag, ks_if.rd_key, exp);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    a1_key    = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
    a1_rk[0]  = a1_key;
    a1_rk[1]  = 128'hA0FAFE1788542CB123A339392A6C7605;
    a1_rk[2]  = 128'hF2C295F27A96B9435935807A7359F67F;
    a1_rk[3]  = 128'h3D80477D4716FE3E1E237E446D7A883B;
    a1_rk[4]  = 128'hEF44A541A8525B7FB671253BDB0BAD00;
    a1_rk[5]  = 128'hD4D1C6F87C839D87CAF2B8BC11F915BC;
    a1_rk[6]  = 128'h6D88A37A110B3EFDDBF98641CA0093FD;
    a1_rk[7]  = 128'h4E54F70E5F5FC9F384A64FB24EA6DC4F;
    a1_rk[8]  = 128'hEAD27321B58DBAD2312BF5607F8D292F;
    a1_rk[9]  = 128'hAC7766F319FADC2128D12941575C006E;
    a1_rk[10] = 128'hD014F9A8C9EE2589E13F0CC8B6630CA6;
    zero_rk1  = 128'h62636363626363636263636362636363;
    zero_rk10 = 128'hB4EF5BCB3E92E21123E951CF6F8F188E;

    ks_if.start  = 1'b0;
    ks_if.key    = '0;
    ks_if.rd_idx = 4'd0;
    reset_n      = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", ks_if.ready, 1'b1);
    check("rst_busy", ks_if.busy, 1'b0);
    check("rst_done", ks_if.done, 1'b0);
    check("rst_keys_valid", ks_if.keys_valid, 1'b0);
    check("rst_rd_key", ks_if.rd_key, '0);
    check("rst_rcon", dut.r_rcon, 32'h01000000);
    check("rst_round", dut.r_round, 4'd0);
    reset_n = 1'b1;
    step(1);

    // FIPS-197 A.1 expansion and latency
    accept_key(a1_key);
    check("s1_busy", ks_if.busy, 1'b1);
    check("s1_ready", ks_if.ready, 1'b0);
    wait_done(n);
    check("s1_latency", n, 20);
    check("s1_keys_valid", ks_if.keys_valid, 1'b1);
    check("s1_ready_done", ks_if.ready, 1'b1);
    step(1);
    check("s1_done_pulse", ks_if.done, 1'b0);
    check("s1_keys_valid_hold", ks_if.keys_valid, 1'b1);
    for (int i = 0; i <= 10; i++) read_key(i, $sformatf("s1_rk%0d", i), a1_rk[i]);

    // Out-of-range indices read zero, index 0 returns the cipher key
    for (int i = 11; i <= 15; i++) read_key(i, $sformatf("s6_oob%0d", i), '0);
    read_key(0, "s6_rk0", a1_key);

    // Start pulses while busy are ignored
    accept_key(a1_key);
    step(2);
    ks_if.start = 1'b1;
    ks_if.key   = '0;
    step(1);
    ks_if.start = 1'b0;
    step(6);
    ks_if.start = 1'b1;
    step(1);
    ks_if.start = 1'b0;
    check("s3_busy", ks_if.busy, 1'b1);
    wait_done(n);
    check("s3_latency", n, 10);
    extra_done = 0;
    for (int i = 0; i < 25; i++) begin
      step(1);
      if (ks_if.done === 1'b1) extra_done++;
    end
    check("s3_single_done", extra_done, 0);
    read_key(1, "s3_rk1", a1_rk[1]);
    read_key(10, "s3_rk10", a1_rk[10]);
    read_key(0, "s3_rk0", a1_key);

    // Reset during round 5, then restart
    accept_key(a1_key);
    step(9);
    #2;
    reset_n = 1'b0;
    #1;
    check("s4_busy", ks_if.busy, 1'b0);
    check("s4_keys_valid", ks_if.keys_valid, 1'b0);
    check("s4_ready", ks_if.ready, 1'b1);
    check("s4_rd_key", ks_if.rd_key, '0);
    step(1);
    reset_n = 1'b1;
    step(1);
    accept_key(a1_key);
    wait_done(n);
    check("s4_latency", n, 20);
    read_key(1, "s4_rk1", a1_rk[1]);
    read_key(5, "s4_rk5", a1_rk[5]);
    read_key(10, "s4_rk10", a1_rk[10]);

    // All-zero key, rcon observed mid round 9
    accept_key('0);
    step(17);
    check("s2_round", dut.r_round, 4'd9);
    check("s2_rcon_r9", dut.r_rcon, 32'h1B000000);
    wait_done(n);
    check("s2_latency_tail", n, 3);

    // Back-to-back start in the done cycle
    check("s5_done_now", ks_if.done, 1'b1);
    accept_key('0);
    check("s5_keys_valid_drop", ks_if.keys_valid, 1'b0);
    check("s5_busy", ks_if.busy, 1'b1);
    check("s5_done_clear", ks_if.done, 1'b0);
    wait_done(n);
    check("s5_latency", n, 20);
    check("s5_keys_valid", ks_if.keys_valid, 1'b1);
    read_key(1, "s5_rk1", zero_rk1);
    read_key(10, "s5_rk10", zero_rk10);
    read_key(0, "s5_rk0", '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
